// File: rtl/uart_pkg.sv
// Shared definitions for the UART command frame parser: state encoding,
// default header bytes and an elaboration-time clog2 helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_EMIT
  } state_t;

  localparam logic [7:0] DEF_HDR0 = 8'h55;
  localparam logic [7:0] DEF_HDR1 = 8'hAA;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while (r < 32 && (32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for one frame: synchronous write, combinational read,
// storage deliberately left without reset.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                                              sclk_100M,
  input  logic                                              we,
  input  logic [((MAX_LEN > 1) ? clog2(MAX_LEN) : 1)-1:0]   waddr,
  input  logic [7:0]                                        wdata,
  input  logic [((MAX_LEN > 1) ? clog2(MAX_LEN) : 1)-1:0]   raddr,
  output logic [7:0]                                        rdata_c
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge sclk_100M) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HDR0 HDR1 ADDR LEN payload CHK frames from the UART byte stream and,
// once the additive checksum matches, replays the payload as register writes.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 100_000,
  parameter logic [7:0]  HDR0        = DEF_HDR0,
  parameter logic [7:0]  HDR1        = DEF_HDR1
) (
  input  logic       sclk_100M,
  input  logic       s_rst_n,
  input  logic [7:0] rx_data,
  input  logic       done_flag,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned IW = clog2(MAX_LEN + 1);
  localparam int unsigned TW = clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? clog2(MAX_LEN) : 1;

  state_t        state;
  logic [7:0]    addr_q;
  logic [7:0]    acc_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tmo_q;

  logic          buf_we_c;
  logic [AW-1:0] buf_waddr_c;
  logic [AW-1:0] buf_raddr_c;
  logic [7:0]    buf_rdata_c;
  logic          tmo_active_c;
  logic          tmo_hit_c;
  logic          len_bad_c;

  // Index 0 is read while checking CHK so the first write can issue on the next edge.
  assign buf_we_c    = done_flag && (state == ST_DATA);
  assign buf_waddr_c = AW'(idx_q);
  assign buf_raddr_c = (state == ST_EMIT) ? AW'(idx_q) : '0;

  assign tmo_active_c = (state == ST_HDR2) || (state == ST_ADDR) || (state == ST_LEN) ||
                        (state == ST_DATA) || (state == ST_CHK);
  assign tmo_hit_c    = tmo_active_c && (tmo_q == TW'(TIMEOUT_CYC));
  assign len_bad_c    = (rx_data == 8'd0) || (32'(rx_data) > MAX_LEN);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .sclk_100M (sclk_100M),
    .we        (buf_we_c),
    .waddr     (buf_waddr_c),
    .wdata     (rx_data),
    .raddr     (buf_raddr_c),
    .rdata_c   (buf_rdata_c)
  );

  always_ff @(posedge sclk_100M) begin
    if (!s_rst_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      acc_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (done_flag || !tmo_active_c) tmo_q <= '0;
      else                            tmo_q <= tmo_q + TW'(1);

      case (state)
        ST_IDLE: begin
          if (done_flag && rx_data == HDR0) begin
            state <= ST_HDR2;
            busy  <= 1'b1;
          end
        end
        ST_HDR2: begin
          // A repeated HDR0 keeps us waiting for HDR1 (resync).
          if (done_flag) begin
            if (rx_data == HDR1) begin
              state <= ST_ADDR;
            end else if (rx_data != HDR0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_ADDR: begin
          if (done_flag) begin
            addr_q <= rx_data;
            acc_q  <= rx_data;
            state  <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (done_flag) begin
            if (len_bad_c) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              len_q <= IW'(rx_data);
              acc_q <= acc_q + rx_data;
              idx_q <= '0;
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (done_flag) begin
            acc_q <= acc_q + rx_data;
            idx_q <= idx_q + IW'(1);
            if (idx_q + IW'(1) == len_q) state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (done_flag) begin
            if (rx_data == acc_q) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_q;
              wr_data <= buf_rdata_c;
              idx_q   <= IW'(1);
              if (len_q == IW'(1)) begin
                frame_ok <= 1'b1;
                state    <= ST_IDLE;
                busy     <= 1'b0;
              end else begin
                state <= ST_EMIT;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
        end
        ST_EMIT: begin
          // Incoming bytes are ignored here; idx_q counts writes already issued.
          wr_en   <= 1'b1;
          wr_addr <= addr_q + 8'(idx_q);
          wr_data <= buf_rdata_c;
          idx_q   <= idx_q + IW'(1);
          if (idx_q + IW'(1) == len_q) begin
            frame_ok <= 1'b1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Inter-byte timeout; a byte arriving on the expiry cycle takes priority.
      if (tmo_hit_c && !done_flag) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level command frame parser placed directly downstream of the UART receiver. It consumes each received byte (`rx_data` qualified by the one-cycle `done_flag` strobe) and recognises framed write commands. It buffers the payload and checks an 8-bit additive checksum. Only after the checksum matches does it replay the payload as a burst of register-write strobes to the local register file.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes per frame (1..64).
- `TIMEOUT_CYC`, 100_000: allowed idle cycles between bytes inside a frame (1 ms at 100 MHz).
- `HDR0`, 8'h55: first header byte.
- `HDR1`, 8'hAA: second header byte.

Ports:
- `sclk_100M`  in  1: system clock; all logic on rising edge.
- `s_rst_n`  in  1: reset, synchronous, active-low.
- `rx_data`  in  8: received byte, valid only when `done_flag`=1.
- `done_flag`  in  1: one-cycle strobe, one per received byte.
- `wr_en`  out  1: register write strobe.
- `wr_addr`  out  8: write address.
- `wr_data`  out  8: write data.
- `frame_ok`  out  1: one-cycle pulse, valid frame fully written.
- `frame_err`  out  1: one-cycle pulse, frame aborted.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- Frame format, in order: `HDR0`, `HDR1`, ADDR, LEN, then LEN payload bytes, then CHK.
- CHK = (ADDR + LEN + Σpayload) mod 256, computed in an 8-bit accumulator that wraps silently.
- The FSM advances only on cycles with `done_flag`=1, except in EMIT.
- IDLE:
  - byte == `HDR0` → HDR2.
  - any other byte is discarded with no error.
- HDR2:
  - byte == `HDR1` → ADDR.
  - byte == `HDR0` → stay in HDR2 (resync).
  - any other byte → IDLE, no error.
- ADDR: latch ADDR, seed the accumulator with it → LEN.
- LEN:
  - LEN == 0 or LEN > `MAX_LEN` → `frame_err`, IDLE.
  - otherwise latch LEN, add it to the accumulator, clear the index → DATA.
- DATA:
  - store the byte at buf[idx], add it to the accumulator, idx++.
  - after the LEN-th byte → CHK.
- CHK:
  - byte == accumulator → EMIT with idx cleared.
  - otherwise → `frame_err`, IDLE, and nothing is written.
- EMIT: one write per cycle with `wr_addr` = (ADDR + idx) mod 256 and `wr_data` = buf[idx]. After LEN writes → IDLE.
- `done_flag` arriving during EMIT: the byte is dropped. Legal traffic cannot hit this case, since a byte period is at least 868 cycles and EMIT lasts at most 64.
- Timeout:
  - The counter is cleared on every `done_flag` and counts in HDR2, ADDR, LEN, DATA and CHK.
  - On reaching `TIMEOUT_CYC` → `frame_err`, IDLE.
  - A `done_flag` in the same cycle as expiry wins: the byte is processed and the counter clears.
- Reset mid-frame or mid-EMIT: at the next edge go to IDLE with all outputs at their reset values. No partial burst resumes.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_ok`=0, `frame_err`=0, `busy`=0; state = IDLE; accumulator, idx and timeout counter = 0.
- All outputs are registered.
- Correct CHK byte strobed in cycle T:
  - `wr_en` is high in cycles T+1 … T+LEN.
  - `frame_ok` pulses in cycle T+LEN, coincident with the last write.
- Error on a byte strobed in cycle T: `frame_err` pulses in T+1 and `busy` falls in T+1.
- Timeout: `frame_err` pulses one cycle after the counter reaches `TIMEOUT_CYC`.
- `frame_ok` and `frame_err` are never high in the same cycle.
- `busy` rises the cycle after the `HDR0` byte is accepted.
- Width rules:
  - idx and LEN registers: clog2(`MAX_LEN`+1) bits.
  - timeout counter: clog2(`TIMEOUT_CYC`+1) bits.

## Structure
- Shared package `uart_pkg`:
  - state encoding: IDLE, HDR2, ADDR, LEN, DATA, CHK, EMIT.
  - default `HDR0`/`HDR1` constants.
  - a clog2 function.
- One sub-module, `uart_frame_buf`:
  - `MAX_LEN`×8 register array.
  - synchronous write port.
  - combinational read port.
  - no reset on storage.
- FSM, accumulator, timeout counter and output registers live in the parent.

## Test plan
- Valid frame: 55 AA 10 03 11 22 33 79 → writes (10,11), (11,22), (12,33) on 3 consecutive cycles, `frame_ok` on the third, no `frame_err`.
- Bad checksum: 55 AA 10 03 11 22 33 78 → zero `wr_en`, one `frame_err` pulse, `busy`=0 afterwards.
- Length bounds:
  - LEN=00 → `frame_err` right after the LEN byte.
  - LEN=`MAX_LEN`+1 → `frame_err`.
  - LEN=`MAX_LEN` with the correct checksum → `MAX_LEN` writes.
- Resync and wrap:
  - 55 55 AA FE 02 01 02 03 → writes (FE,01), (FF,02); the address wraps with no error.
  - Leading junk bytes (00, 13) before the header are ignored.
- Timeout: after 55 AA 10, stall `TIMEOUT_CYC` cycles → exactly one `frame_err`. A following valid frame is then accepted normally.
- Reset: deassert `s_rst_n` for one cycle midway through DATA and again mid-EMIT → all outputs 0 at the next edge, and the next valid frame parses correctly.
